// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Purpose  : Load/store unit for the memory stage. Accepts one access at a
//            time, checks alignment and funct3 legality, drives a
//            single-outstanding req/gnt/rvalid bus with byte enables and
//            lane-replicated store data, and sign/zero extends load data.
// Ports    : i_clk, i_rst_n          clock, synchronous active-low reset
//            i_valid/i_mem_re/i_mem_we/i_funct3/i_addr/i_wdata
//                                     memory-stage instruction
//            o_stall                 hold the pipeline
//            o_rdata/o_rdata_valid   extended load result and its pulse
//            o_misaligned            misaligned access, no bus traffic
//            o_bus_*/i_bus_*         request/grant/rvalid data bus
// Revision : 1.0 - initial release
// ============================================================================
module lsu #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_mem_re,
    input  logic            i_mem_we,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_rdata_valid,
    output logic            o_misaligned,
    output logic            o_bus_req,
    input  logic            i_bus_gnt,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [3:0]      o_bus_be,
    output logic [XLEN-1:0] o_bus_wdata,
    input  logic            i_bus_rvalid,
    input  logic [XLEN-1:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [1:0]      off;
    logic [2:0]      funct3_q;

    logic            access;
    logic            legal;
    logic            misaligned;
    logic            accept;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;

    assign access = i_valid & (i_mem_re | i_mem_we);

    // A store wins when both control bits are set, so legality follows we.
    always_comb begin
        legal = 1'b0;
        if (i_mem_we) begin
            legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
        end else begin
            legal = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                    (i_funct3 == 3'b100) || (i_funct3 == 3'b101);
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b01:   misaligned = i_addr[0];
            2'b10:   misaligned = (i_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign accept       = (state == ST_IDLE) & access & legal & ~misaligned;
    assign o_misaligned = (state == ST_IDLE) & access & legal & misaligned;
    assign o_stall      = accept | (state == ST_REQ) | (state == ST_WAIT);

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << i_addr[1:0];
                wdata_next = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_next    = 4'b0011 << i_addr[1:0];
                wdata_next = {2{i_wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = i_wdata;
            end
        endcase
        if (!i_mem_we) begin
            wdata_next = '0;
        end
    end

    // Move the addressed lane down to bit 0, then extend by size/sign.
    assign shifted = i_bus_rdata >> {off, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  load_ext = {16'b0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            off           <= 2'b00;
            funct3_q      <= 3'b000;
            o_bus_req     <= 1'b0;
            o_bus_we      <= 1'b0;
            o_bus_addr    <= '0;
            o_bus_be      <= 4'b0000;
            o_bus_wdata   <= '0;
            o_rdata       <= '0;
            o_rdata_valid <= 1'b0;
        end else begin
            o_rdata_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_REQ;
                        off         <= i_addr[1:0];
                        funct3_q    <= i_funct3;
                        o_bus_req   <= 1'b1;
                        o_bus_we    <= i_mem_we;
                        o_bus_addr  <= {i_addr[XLEN-1:2], 2'b00};
                        o_bus_be    <= be_next;
                        o_bus_wdata <= wdata_next;
                    end
                end
                ST_REQ: begin
                    if (i_bus_gnt) begin
                        o_bus_req <= 1'b0;
                        state     <= o_bus_we ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_bus_rvalid) begin
                        o_rdata       <= load_ext;
                        o_rdata_valid <= 1'b1;
                        state         <= ST_DONE;
                    end
                end
                default: begin
                    // The same instruction is still presented here; it must
                    // not be accepted a second time.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Purpose  : Self-checking bench for lsu. Directed cases plus randomized
//            accesses with random grant/rvalid latency, compared against a
//            byte-level reference model of the access rules.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, mem_re, mem_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, rdata_valid, misaligned;
    logic [31:0] rdata;
    logic        bus_req, bus_gnt, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int total = 0;
    int bad   = 0;

    // Reference state tracked by the model.
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;
    logic        m_we;

    always #5 clk = ~clk;

    lsu #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mem_re(mem_re),
        .i_mem_we(mem_we), .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
        .o_stall(stall), .o_rdata(rdata), .o_rdata_valid(rdata_valid),
        .o_misaligned(misaligned), .o_bus_req(bus_req), .i_bus_gnt(bus_gnt),
        .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_be(bus_be),
        .o_bus_wdata(bus_wdata), .i_bus_rvalid(bus_rvalid), .i_bus_rdata(bus_rdata)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 < 3);
        return (f3 < 3) || (f3 == 4) || (f3 == 5);
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int n = nbytes(f3);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r = '0;
        int n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v = rd >> (8 * (a % 4));
        int bits = 8 * nbytes(f3);
        logic [31:0] mask;
        if (bits == 32) return v;
        mask = (32'd1 << bits) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic check_bus(input string tag);
        check_val({tag, ".req"},   bus_req,   1);
        check_val({tag, ".stall"}, stall,     1);
        check_val({tag, ".addr"},  bus_addr,  m_addr);
        check_val({tag, ".be"},    bus_be,    m_be);
        check_val({tag, ".we"},    bus_we,    m_we);
        check_val({tag, ".wdata"}, bus_wdata, m_wdata);
    endtask

    task automatic do_access(input logic re, input logic we, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int gd, input int rvd);
        logic acc = re | we;
        logic lg  = acc && is_legal(we, f3);
        logic mis = lg && ((a % nbytes(f3)) != 0);
        logic go  = lg && !mis;
        @(posedge clk); #1;
        valid = 1'b1; mem_re = re; mem_we = we; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        check_val("idle.misaligned", misaligned, mis);
        check_val("idle.stall", stall, go);
        if (!go) begin
            @(posedge clk); #1;
            valid = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
            @(negedge clk);
            check_val("drop.req", bus_req, 0);
            check_val("drop.stall", stall, 0);
            check_val("drop.addr", bus_addr, m_addr);
            return;
        end
        m_addr  = a & ~32'd3;
        m_be    = model_be(f3, a);
        m_we    = we;
        m_wdata = we ? model_wdata(f3, wd) : 32'd0;
        @(posedge clk); #1;
        for (int i = 0; i < gd; i++) begin
            bus_rvalid = 1'($urandom % 2);
            bus_rdata  = $urandom;
            @(negedge clk);
            check_bus("req.wait");
            check_val("req.rvalid_out", rdata_valid, 0);
            @(posedge clk); #1;
        end
        bus_rvalid = 1'b0;
        bus_gnt    = 1'b1;
        @(negedge clk);
        check_bus("req.gnt");
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        if (!we) begin
            for (int i = 0; i < rvd; i++) begin
                bus_gnt = 1'($urandom % 2);
                @(negedge clk);
                check_val("wait.stall", stall, 1);
                check_val("wait.req", bus_req, 0);
                check_val("wait.rvalid_out", rdata_valid, 0);
                @(posedge clk); #1;
            end
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b1;
            bus_rdata  = rd;
            @(negedge clk);
            check_val("wait.stall", stall, 1);
            @(posedge clk); #1;
            bus_rvalid = 1'b0;
            m_rdata = model_load(f3, a, rd);
        end
        @(negedge clk);
        check_val("done.stall", stall, 0);
        check_val("done.rdata_valid", rdata_valid, !we);
        check_val("done.rdata", rdata, m_rdata);
        check_val("done.req", bus_req, 0);
        @(posedge clk); #1;
        valid = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        @(negedge clk);
        check_val("after.rdata_valid", rdata_valid, 0);
        check_val("after.req", bus_req, 0);
        check_val("after.addr", bus_addr, m_addr);
        check_val("after.be", bus_be, m_be);
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; mem_re = 1'b0; mem_we = 1'b0; funct3 = '0;
        addr = '0; wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; m_be = '0; m_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst.req", bus_req, 0);
        check_val("rst.we", bus_we, 0);
        check_val("rst.addr", bus_addr, 0);
        check_val("rst.be", bus_be, 0);
        check_val("rst.wdata", bus_wdata, 0);
        check_val("rst.rdata", rdata, 0);
        check_val("rst.rdata_valid", rdata_valid, 0);
        check_val("rst.stall", stall, 0);
        check_val("rst.misaligned", misaligned, 0);
        rst_n = 1'b1;

        // Directed cases.
        do_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 2, 0);
        do_access(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, 0);
        do_access(1, 0, 3'b000, 32'h301, 0, 32'h12348000, 1, 1);
        do_access(1, 0, 3'b100, 32'h301, 0, 32'h12348000, 0, 0);
        do_access(1, 0, 3'b001, 32'h402, 0, 32'h9ABC0000, 0, 2);
        do_access(1, 0, 3'b101, 32'h402, 0, 32'h9ABC0000, 2, 0);
        do_access(1, 0, 3'b010, 32'h102, 0, 0, 0, 0);
        do_access(0, 1, 3'b001, 32'h101, 32'h1234, 0, 0, 0);
        do_access(1, 1, 3'b001, 32'h102, 32'h0000BEEF, 0, 1, 0);
        do_access(1, 0, 3'b110, 32'h100, 0, 0, 0, 0);
        do_access(0, 1, 3'b011, 32'h100, 0, 0, 0, 0);

        // Randomized accesses.
        for (int n = 0; n < 150; n++) begin
            logic [2:0]  f3 = 3'($urandom);
            logic [31:0] a  = $urandom;
            logic        re = 1'($urandom);
            logic        we = 1'($urandom);
            if ($urandom % 2) a = a & ~32'd3;
            do_access(re, we, f3, a, $urandom, $urandom, $urandom_range(0, 3),
                      $urandom_range(0, 3));
        end

        // Reset while a load waits for read data; the late rvalid is ignored.
        @(posedge clk); #1;
        valid = 1'b1; mem_re = 1'b1; funct3 = 3'b010; addr = 32'h500;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0; valid = 1'b0; mem_re = 1'b0;
        @(negedge clk);
        check_val("rstw.stall", stall, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check_val("rstw.req", bus_req, 0);
        check_val("rstw.stall", stall, 0);
        check_val("rstw.rdata_valid", rdata_valid, 0);
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        @(negedge clk);
        check_val("rstw.rdata_valid2", rdata_valid, 0);
        check_val("rstw.rdata", rdata, 0);
        check_val("rstw.addr", bus_addr, 0);
        check_val("rstw.be", bus_be, 0);
        m_addr = '0; m_be = '0; m_wdata = '0; m_rdata = '0; m_we = 1'b0;

        do_access(1, 0, 3'b000, 32'h7, 0, 32'h80000000, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
